// File: rtl/mc_core_pkg.sv
// mc_core_pkg: shared constants and helpers for the multi-cycle sequencer.
//   - FSM state encodings
//   - trap cause codes
//   - memop (funct3-style) encodings
//   - decoded-control struct latched in EXEC
//   - memop size/legality helpers
package mc_core_pkg;

  localparam logic [2:0] ST_BOOT       = 3'd0;
  localparam logic [2:0] ST_FETCH_REQ  = 3'd1;
  localparam logic [2:0] ST_FETCH_WAIT = 3'd2;
  localparam logic [2:0] ST_EXEC       = 3'd3;
  localparam logic [2:0] ST_MEM_REQ    = 3'd4;
  localparam logic [2:0] ST_MEM_WAIT   = 3'd5;
  localparam logic [2:0] ST_WB         = 3'd6;
  localparam logic [2:0] ST_TRAP       = 3'd7;

  localparam logic [2:0] CAUSE_NONE      = 3'd0;
  localparam logic [2:0] CAUSE_FETCH_ERR = 3'd1;
  localparam logic [2:0] CAUSE_PC_MIS    = 3'd2;
  localparam logic [2:0] CAUSE_LS_MIS    = 3'd3;
  localparam logic [2:0] CAUSE_TIMEOUT   = 3'd4;
  localparam logic [2:0] CAUSE_ILL_MEMOP = 3'd5;
  localparam logic [2:0] CAUSE_LS_ERR    = 3'd6;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_D  = 3'b011;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;
  localparam logic [2:0] MEMOP_WU = 3'b110;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic [2:0] memop;
  } dec_t;

  // Access size in bytes; low two bits of memop carry the size.
  function automatic logic [3:0] memop_bytes(input logic [2:0] m);
    case (m[1:0])
      2'd0:    return 4'd1;
      2'd1:    return 4'd2;
      2'd2:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // Doubleword and unsigned-word only exist on a 64-bit datapath.
  function automatic logic memop_legal(input logic [2:0] m, input int xlen);
    case (m)
      MEMOP_B, MEMOP_H, MEMOP_W, MEMOP_BU, MEMOP_HU: return 1'b1;
      MEMOP_D, MEMOP_WU:                             return (xlen == 64);
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_core_seq_if.sv
// mc_core_seq_if: shared valid/ready memory bus.
//   master (core): bus_req/addr/wen/wdata/wmask out; bus_gnt/rvalid/rdata/err in
//   slave  (memory): the mirror image
interface mc_core_seq_if #(parameter int XLEN = 32);
  logic              bus_req;
  logic [XLEN-1:0]   bus_addr;
  logic              bus_wen;
  logic [XLEN-1:0]   bus_wdata;
  logic [XLEN/8-1:0] bus_wmask;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [XLEN-1:0]   bus_rdata;
  logic              bus_err;

  modport master (
    output bus_req, bus_addr, bus_wen, bus_wdata, bus_wmask,
    input  bus_gnt, bus_rvalid, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_addr, bus_wen, bus_wdata, bus_wmask,
    output bus_gnt, bus_rvalid, bus_rdata, bus_err
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane alignment for loads and stores.
//   memop      : funct3-style size/sign code
//   offset     : byte offset of the address within the bus word
//   store_data : rs2 value, replicated across lanes on wdata
//   rdata      : raw bus read data
//   wmask      : size mask shifted to the addressed lanes
//   ldata      : read data shifted down and sign/zero-extended to XLEN
module lsu_align
  import mc_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                  memop,
  input  logic [$clog2(XLEN/8)-1:0]   offset,
  input  logic [XLEN-1:0]             store_data,
  input  logic [XLEN-1:0]             rdata,
  output logic [XLEN/8-1:0]           wmask,
  output logic [XLEN-1:0]             wdata,
  output logic [XLEN-1:0]             ldata
);
  localparam int NB = XLEN / 8;

  logic [NB-1:0]   base_mask;
  logic [XLEN-1:0] shifted;

  always_comb begin
    base_mask = '0;
    wdata     = store_data;
    case (memop[1:0])
      2'd0: begin
        base_mask = NB'(8'h01);
        wdata     = {(XLEN/8){store_data[7:0]}};
      end
      2'd1: begin
        base_mask = NB'(8'h03);
        wdata     = {(XLEN/16){store_data[15:0]}};
      end
      2'd2: begin
        base_mask = NB'(8'h0F);
        wdata     = {(XLEN/32){store_data[31:0]}};
      end
      default: begin
        base_mask = NB'(8'hFF);
        wdata     = store_data;
      end
    endcase
    wmask = base_mask << offset;
  end

  // memop[2] selects zero-extension; the signed cast sign-extends otherwise.
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (memop[1:0])
      2'd0:    ldata = memop[2] ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      2'd1:    ldata = memop[2] ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      2'd2:    ldata = memop[2] ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      default: ldata = shifted;
    endcase
  end

endmodule

// File: rtl/mc_core_seq.sv
// mc_core_seq: multi-cycle fetch/exec/mem/writeback sequencer on a shared bus.
//   clk, rst          : clock, async active-high reset
//   bus               : valid/ready memory bus (master side)
//   pc, instr         : current PC and latched instruction
//   instr_valid       : high in EXEC, when external decode/ALU results are sampled
//   dec_*, mem_addr, store_data, alu_result, next_pc : external combinational results
//   rf_we, rf_wdata   : register-file write port (WB only)
//   trap, trap_cause  : sticky trap flag and cause
module mc_core_seq
  import mc_core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
  parameter int unsigned     TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  mc_core_seq_if.master     bus,
  output logic [XLEN-1:0]   pc,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              dec_mem_rd,
  input  logic              dec_mem_wr,
  input  logic              dec_reg_wr,
  input  logic [2:0]        dec_memop,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   next_pc,
  output logic              rf_we,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              trap,
  output logic [2:0]        trap_cause
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 2);

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [2:0]      cause_q, cause_d;
  logic [XLEN-1:0] npc_q, npc_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic [XLEN-1:0] maddr_q, maddr_d;
  logic [XLEN-1:0] sdata_q, sdata_d;
  logic [XLEN-1:0] ldata_q, ldata_d;
  dec_t            dec_q, dec_d;

  logic            pc_mis, is_load, timed_out;
  logic            ex_mem, ex_mis;
  logic [NB-1:0]   lsu_wmask;
  logic [XLEN-1:0] lsu_wdata, lsu_ldata;

  lsu_align #(.XLEN(XLEN)) u_lsu (
    .memop      (dec_q.memop),
    .offset     (maddr_q[OW-1:0]),
    .store_data (sdata_q),
    .rdata      (bus.bus_rdata),
    .wmask      (lsu_wmask),
    .wdata      (lsu_wdata),
    .ldata      (lsu_ldata)
  );

  assign pc_mis  = (pc_q[1:0] != 2'b00);
  assign is_load = dec_q.mem_rd & ~dec_q.mem_wr;
  assign cnt_inc = cnt_q + CW'(1);
  // Counts the current cycle, so a never-granted request is visible for
  // exactly TIMEOUT cycles before the trap.
  assign timed_out = (TIMEOUT != 0) && (32'(cnt_inc) == TIMEOUT);

  assign ex_mem = dec_mem_rd | dec_mem_wr;
  assign ex_mis = (mem_addr[3:0] & (memop_bytes(dec_memop) - 4'd1)) != 4'd0;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    npc_d   = npc_q;
    alu_d   = alu_q;
    maddr_d = maddr_q;
    sdata_d = sdata_q;
    ldata_d = ldata_q;
    dec_d   = dec_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH_REQ;
        cnt_d   = '0;
      end
      ST_FETCH_REQ: begin
        if (pc_mis) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_PC_MIS;
        end else begin
          cnt_d = cnt_inc;
          if (bus.bus_gnt) state_d = ST_FETCH_WAIT;
          else if (timed_out) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_TIMEOUT;
          end
        end
      end
      ST_FETCH_WAIT: begin
        cnt_d = cnt_inc;
        if (bus.bus_rvalid) begin
          if (bus.bus_err) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_FETCH_ERR;
          end else begin
            instr_d = (XLEN == 64 && pc_q[2]) ? bus.bus_rdata[XLEN-1 -: 32]
                                              : bus.bus_rdata[31:0];
            state_d = ST_EXEC;
          end
        end else if (timed_out) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_EXEC: begin
        npc_d   = next_pc;
        alu_d   = alu_result;
        maddr_d = mem_addr;
        sdata_d = store_data;
        // rd+wr together is treated as a store
        dec_d   = '{mem_rd: dec_mem_rd & ~dec_mem_wr, mem_wr: dec_mem_wr,
                    reg_wr: dec_reg_wr, memop: dec_memop};
        if (ex_mem) begin
          if (!memop_legal(dec_memop, XLEN)) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_ILL_MEMOP;
          end else if (ex_mis) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_LS_MIS;
          end else begin
            state_d = ST_MEM_REQ;
            cnt_d   = '0;
          end
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM_REQ: begin
        cnt_d = cnt_inc;
        if (bus.bus_gnt) state_d = ST_MEM_WAIT;
        else if (timed_out) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_MEM_WAIT: begin
        cnt_d = cnt_inc;
        if (bus.bus_rvalid) begin
          if (bus.bus_err) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_LS_ERR;
          end else begin
            ldata_d = lsu_ldata;
            state_d = ST_WB;
          end
        end else if (timed_out) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_WB: begin
        pc_d    = npc_q;
        state_d = ST_FETCH_REQ;
        cnt_d   = '0;
      end
      default: ; // ST_TRAP absorbs until reset
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
      npc_q   <= '0;
      alu_q   <= '0;
      maddr_q <= '0;
      sdata_q <= '0;
      ldata_q <= '0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      npc_q   <= npc_d;
      alu_q   <= alu_d;
      maddr_q <= maddr_d;
      sdata_q <= sdata_d;
      ldata_q <= ldata_d;
      dec_q   <= dec_d;
    end
  end

  // Bus outputs decode purely from state, so reset silences them at once.
  always_comb begin
    bus.bus_req   = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_wen   = 1'b0;
    bus.bus_wdata = '0;
    bus.bus_wmask = '0;
    case (state_q)
      ST_FETCH_REQ: begin
        if (!pc_mis) begin
          bus.bus_req  = 1'b1;
          bus.bus_addr = pc_q;
        end
      end
      ST_MEM_REQ: begin
        bus.bus_req  = 1'b1;
        bus.bus_addr = maddr_q;
        bus.bus_wen  = dec_q.mem_wr;
        if (dec_q.mem_wr) begin
          bus.bus_wmask = lsu_wmask;
          bus.bus_wdata = lsu_wdata;
        end
      end
      default: ;
    endcase
  end

  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == ST_EXEC);
  assign rf_we       = (state_q == ST_WB) & dec_q.reg_wr;
  assign rf_wdata    = (state_q == ST_WB) ? (is_load ? ldata_q : alu_q) : '0;
  assign trap        = (state_q == ST_TRAP);
  assign trap_cause  = cause_q;

endmodule

// File: tb/tb_mc_core_seq.sv
module tb_mc_core_seq;
  logic        clk, rst, rst2;
  logic        dec_mem_rd, dec_mem_wr, dec_reg_wr;
  logic [2:0]  dec_memop;
  logic [31:0] mem_addr, store_data, alu_result, next_pc;
  logic [31:0] pc, instr, rf_wdata;
  logic        instr_valid, rf_we, trap;
  logic [2:0]  trap_cause;
  logic [31:0] pc2, instr2, rf_wdata2;
  logic        instr_valid2, rf_we2, trap2;
  logic [2:0]  trap_cause2;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  mc_core_seq_if #(.XLEN(32)) bus_if ();
  mc_core_seq_if #(.XLEN(32)) bus2_if ();

  mc_core_seq #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .bus(bus_if.master),
    .pc(pc), .instr(instr), .instr_valid(instr_valid),
    .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr), .dec_reg_wr(dec_reg_wr),
    .dec_memop(dec_memop), .mem_addr(mem_addr), .store_data(store_data),
    .alu_result(alu_result), .next_pc(next_pc),
    .rf_we(rf_we), .rf_wdata(rf_wdata), .trap(trap), .trap_cause(trap_cause)
  );

  // Same core with the timeout disabled and a bus that never grants.
  mc_core_seq #(.XLEN(32), .TIMEOUT(0)) dut_nto (
    .clk(clk), .rst(rst2), .bus(bus2_if.master),
    .pc(pc2), .instr(instr2), .instr_valid(instr_valid2),
    .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr), .dec_reg_wr(dec_reg_wr),
    .dec_memop(dec_memop), .mem_addr(mem_addr), .store_data(store_data),
    .alu_result(alu_result), .next_pc(next_pc),
    .rf_we(rf_we2), .rf_wdata(rf_wdata2), .trap(trap2), .trap_cause(trap_cause2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_dec(input logic rd, input logic wr, input logic rw, input logic [2:0] op,
                         input logic [31:0] ma, input logic [31:0] sd,
                         input logic [31:0] alu, input logic [31:0] npc);
    dec_mem_rd = rd; dec_mem_wr = wr; dec_reg_wr = rw; dec_memop = op;
    mem_addr = ma; store_data = sd; alu_result = alu; next_pc = npc;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_err = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  // Returns at the negedge of the first cycle with bus_req high.
  task automatic wait_req(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.bus_req) begin ok = 1'b1; break; end
    end
  endtask

  // gnt one cycle after req, rvalid the cycle after gnt.
  task automatic handshake(input logic [31:0] rd, input logic err);
    @(negedge clk); bus_if.bus_gnt = 1'b1;
    @(negedge clk); bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata = rd; bus_if.bus_err = err;
    @(negedge clk); bus_if.bus_rvalid = 1'b0; bus_if.bus_err = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] rd,
                       input logic err, output int t);
    logic ok;
    wait_req(ok);
    t = cyc;
    chk({tag, " fetch req"}, 32'(ok), 32'd1);
    chk({tag, " fetch addr"}, bus_if.bus_addr, addr);
    chk({tag, " fetch wen/wmask"}, {27'b0, bus_if.bus_wen, bus_if.bus_wmask}, 32'd0);
    handshake(rd, err);
  endtask

  task automatic exec_chk(input string tag);
    chk({tag, " instr_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, " instr"}, instr, 32'h0000_0013);
  endtask

  int  t0, t1, n;
  logic ok;

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0; bus_if.bus_err = 1'b0;
    bus2_if.bus_gnt = 1'b0; bus2_if.bus_rvalid = 1'b0; bus2_if.bus_rdata = '0; bus2_if.bus_err = 1'b0;
    set_dec(0, 0, 0, 3'b000, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset pc", pc, 32'h8000_0000);
    chk("reset outs", {26'b0, trap, trap_cause, bus_if.bus_req, instr_valid, rf_we}, 32'd0);
    chk("reset instr", instr, 32'd0);
    rst = 1'b0; rst2 = 1'b0;

    // ALU op: writeback of alu_result, 5-cycle instruction period
    set_dec(0, 0, 1, 3'b000, 0, 0, 32'd5, 32'h8000_0004);
    fetch("alu", 32'h8000_0000, 32'h0000_0013, 1'b0, t0);
    exec_chk("alu");
    @(negedge clk);
    chk("alu rf_we", 32'(rf_we), 32'd1);
    chk("alu rf_wdata", rf_wdata, 32'd5);

    // lb: sign-extended top byte
    set_dec(1, 0, 1, 3'b000, 32'h8000_1003, 0, 0, 32'h8000_0008);
    fetch("lb", 32'h8000_0004, 32'h0000_0013, 1'b0, t1);
    chk("period", 32'(t1 - t0), 32'd5);
    exec_chk("lb");
    wait_req(ok);
    chk("lb mem addr", bus_if.bus_addr, 32'h8000_1003);
    chk("lb wen/wmask", {27'b0, bus_if.bus_wen, bus_if.bus_wmask}, 32'd0);
    handshake(32'h80AA_BBCC, 1'b0);
    chk("lb rf_we", 32'(rf_we), 32'd1);
    chk("lb rf_wdata", rf_wdata, 32'hFFFF_FF80);

    // lbu: zero-extended
    set_dec(1, 0, 1, 3'b100, 32'h8000_1003, 0, 0, 32'h8000_000C);
    fetch("lbu", 32'h8000_0008, 32'h0000_0013, 1'b0, t0);
    wait_req(ok);
    handshake(32'h80AA_BBCC, 1'b0);
    chk("lbu rf_wdata", rf_wdata, 32'h0000_0080);

    // sh at offset 2: upper lanes, replicated data, no register write
    set_dec(0, 1, 0, 3'b001, 32'h8000_1002, 32'h0000_BEEF, 32'h1234, 32'h8000_0010);
    fetch("sh", 32'h8000_000C, 32'h0000_0013, 1'b0, t0);
    wait_req(ok);
    chk("sh wen", 32'(bus_if.bus_wen), 32'd1);
    chk("sh wmask", 32'(bus_if.bus_wmask), 32'h0000_000C);
    chk("sh wdata", bus_if.bus_wdata, 32'hBEEF_BEEF);
    handshake(32'h0, 1'b0);
    chk("sh rf_we", 32'(rf_we), 32'd0);

    // lw misaligned: trap cause 3, no MEM_REQ, pc frozen
    set_dec(1, 0, 1, 3'b010, 32'h8000_1001, 0, 0, 32'h8000_0014);
    fetch("lwmis", 32'h8000_0010, 32'h0000_0013, 1'b0, t0);
    exec_chk("lwmis");
    @(negedge clk);
    chk("lwmis trap/cause", {28'b0, trap, trap_cause}, 32'h0000_000B);
    chk("lwmis pc", pc, 32'h8000_0010);
    chk("lwmis req/rf_we", {30'b0, bus_if.bus_req, rf_we}, 32'd0);
    repeat (3) @(negedge clk);
    chk("lwmis held", {26'b0, bus_if.bus_req, rf_we, trap, trap_cause}, 32'h0000_000B);

    // next_pc misaligned: next fetch traps without a request
    do_reset();
    set_dec(0, 0, 1, 3'b000, 0, 0, 32'd7, 32'h8000_0002);
    fetch("pcmis", 32'h8000_0000, 32'h0000_0013, 1'b0, t0);
    @(negedge clk);
    chk("pcmis wb", {rf_we, rf_wdata[30:0]}, 32'h8000_0007);
    @(negedge clk);
    chk("pcmis no req", 32'(bus_if.bus_req), 32'd0);
    chk("pcmis pc", pc, 32'h8000_0002);
    @(negedge clk);
    chk("pcmis trap/cause", {27'b0, bus_if.bus_req, trap, trap_cause}, 32'h0000_000A);

    // fetch bus error
    do_reset();
    fetch("ferr", 32'h8000_0000, 32'h0000_0013, 1'b1, t0);
    chk("ferr trap/cause", {27'b0, instr_valid, trap, trap_cause}, 32'h0000_0009);

    // doubleword on a 32-bit core is illegal
    do_reset();
    set_dec(1, 0, 1, 3'b011, 32'h8000_1000, 0, 0, 32'h8000_0004);
    fetch("ill", 32'h8000_0000, 32'h0000_0013, 1'b0, t0);
    @(negedge clk);
    chk("ill trap/cause", {27'b0, bus_if.bus_req, trap, trap_cause}, 32'h0000_000D);

    // load bus error
    do_reset();
    set_dec(1, 0, 1, 3'b010, 32'h8000_1000, 0, 0, 32'h8000_0004);
    fetch("lserr", 32'h8000_0000, 32'h0000_0013, 1'b0, t0);
    wait_req(ok);
    chk("lserr mem addr", bus_if.bus_addr, 32'h8000_1000);
    handshake(32'h0, 1'b1);
    chk("lserr trap/cause", {27'b0, rf_we, trap, trap_cause}, 32'h0000_000E);

    // no grant: TIMEOUT=4 allows exactly 4 request cycles
    do_reset();
    wait_req(ok);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.bus_req) n++;
      else break;
    end
    chk("timeout req cycles", 32'(n), 32'd4);
    chk("timeout trap/cause", {27'b0, bus_if.bus_req, trap, trap_cause}, 32'h0000_000C);

    // reset during MEM_WAIT, then a stale response
    do_reset();
    set_dec(1, 0, 1, 3'b010, 32'h8000_1000, 0, 0, 32'h8000_0004);
    fetch("rstmw", 32'h8000_0000, 32'h0000_0013, 1'b0, t0);
    wait_req(ok);
    @(negedge clk); bus_if.bus_gnt = 1'b1;
    @(negedge clk); bus_if.bus_gnt = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstmw req", 32'(bus_if.bus_req), 32'd0);
    chk("rstmw pc", pc, 32'h8000_0000);
    @(negedge clk);
    rst = 1'b0; bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rstmw refetch", {bus_if.bus_req, bus_if.bus_addr[30:0]}, 32'h8000_0000);
    @(negedge clk);
    bus_if.bus_rvalid = 1'b0;
    chk("rstmw still req", {26'b0, bus_if.bus_req, instr_valid, rf_we, trap_cause}, 32'h0000_0020);
    chk("rstmw instr", instr, 32'd0);

    // timeout disabled: still requesting after 1000 cycles
    repeat (1000) @(negedge clk);
    chk("no-timeout trap", {30'b0, trap2, bus2_if.bus_req}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/mc_core_seq.md
Name: mc_core_seq

Overview:
Multi-cycle sequencer that replaces the single-cycle PC/fetch path with a shared valid/ready memory bus. It owns the PC register and steps each instruction through fetch, execute, optional memory access and writeback. Decode, ALU and next-PC arithmetic stay outside; this block consumes their combinational results. It adds load/store byte-lane alignment, XLEN generalisation, a bus timeout and sticky traps.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
RESET_PC, 32'h80000000 (zero-extended to XLEN), PC value loaded on reset.
TIMEOUT, 255, maximum wait cycles per bus transaction; 0 disables the timeout.

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-high
bus_req  out  1  request valid
bus_addr  out  XLEN  request address
bus_wen  out  1  1 = write
bus_wdata  out  XLEN  lane-replicated store data
bus_wmask  out  XLEN/8  byte write enables
bus_gnt  in  1  request accepted this cycle
bus_rvalid  in  1  response valid, for reads and writes
bus_rdata  in  XLEN  read data
bus_err  in  1  response error, qualified by bus_rvalid
pc  out  XLEN  current PC
instr  out  32  latched instruction
instr_valid  out  1  high only in EXEC
dec_mem_rd / dec_mem_wr / dec_reg_wr  in  1 each  decoded controls, sampled in EXEC
dec_memop  in  3  funct3-style size/sign code
mem_addr  in  XLEN  effective address from ALU
store_data  in  XLEN  rs2 value
alu_result  in  XLEN  writeback value for non-loads
next_pc  in  XLEN  next PC from external logic
rf_we  out  1  register-file write enable
rf_wdata  out  XLEN  register-file write data
trap  out  1  sticky trap flag
trap_cause  out  3  0 none, 1 fetch bus error, 2 misaligned PC, 3 misaligned load/store, 4 bus timeout, 5 illegal memop, 6 load/store bus error

Behaviour:
- Reset (asynchronous): state=BOOT, pc=RESET_PC, instr=0, trap=0, trap_cause=0, timeout counter=0. All bus_* outputs, rf_we and instr_valid are 0 immediately, including mid-transaction. Any late bus response after reset release is ignored.
- States: BOOT, FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, TRAP.
- BOOT -> FETCH_REQ after one cycle.
- FETCH_REQ:
  - If pc[1:0]!=0 -> TRAP, cause 2; no request is issued.
  - Otherwise bus_req=1, bus_addr=pc, bus_wen=0, bus_wmask=0. Address and controls are held stable until bus_gnt.
  - On gnt -> FETCH_WAIT.
- FETCH_WAIT:
  - bus_rvalid is only sampled here and in MEM_WAIT; the earliest valid response is the cycle after gnt.
  - On rvalid & !err: instr <= rdata[31:0] (for XLEN=64, the half selected by pc[2]) -> EXEC.
  - On rvalid & err -> TRAP, cause 1.
- EXEC (exactly 1 cycle, instr_valid=1):
  - Latch next_pc, alu_result, mem_addr, store_data and the dec_* signals.
  - If dec_mem_rd|dec_mem_wr:
    - illegal memop -> TRAP, cause 5. Legal: 000 b, 001 h, 010 w, 100 bu, 101 hu; 011 d and 110 wu only when XLEN=64.
    - else misaligned for its size -> TRAP, cause 3.
    - else -> MEM_REQ.
  - Otherwise -> WB.
  - If rd and wr are both set, treat as a store.
- MEM_REQ:
  - bus_req=1, bus_addr=latched mem_addr, bus_wen=dec_mem_wr.
  - Store: bus_wmask = size mask shifted by addr offset; bus_wdata = store_data replicated across lanes.
  - Load: bus_wmask=0.
  - Hold until gnt -> MEM_WAIT.
- MEM_WAIT:
  - rvalid & err -> TRAP, cause 6.
  - rvalid & !err -> WB. For loads, capture rdata shifted right by offset*8, then sign- or zero-extend to XLEN.
- WB (1 cycle):
  - rf_we = latched dec_reg_wr.
  - rf_wdata = extended load data when the instruction was a load, else alu_result.
  - pc <= latched next_pc -> FETCH_REQ.
- Timeout:
  - The counter clears on entry to any REQ state and increments each cycle spent in REQ or WAIT.
  - When it equals TIMEOUT (TIMEOUT!=0) -> TRAP, cause 4.
  - Reaching TIMEOUT in the same cycle as gnt/rvalid: the handshake wins.
- TRAP: absorbing until reset. trap=1, trap_cause held, pc frozen at the faulting instruction, all bus/rf outputs 0.
- rf_we is never asserted for a trapping instruction.

Decomposition:
- Package mc_core_pkg: state enum, trap cause constants, memop encodings, function for size-from-memop.
- One combinational sub-module lsu_align: store mask/data lane generation and load extract/extend, parametrised by XLEN.

Test Plan:
- Reset, then gnt and rvalid each 1 cycle after req, rdata=32'h00000013, no mem op, alu_result=5, next_pc=pc+4 -> bus_addr=32'h80000000, rf_we pulse with wdata=5, second fetch at 32'h80000004; one instruction per 5 cycles.
- lb at mem_addr=32'h80001003, rdata=32'h80AABBCC -> bus_wmask=0, rf_wdata=32'hFFFFFF80. Same access with lbu -> 32'h00000080.
- sh at mem_addr=...02, store_data=32'h0000BEEF -> bus_wmask=4'b1100, bus_wdata=32'hBEEFBEEF, bus_wen=1, rf_we stays 0.
- lw at addr ...01 -> TRAP, cause 3, no MEM_REQ issued. next_pc=...02 -> next fetch traps with cause 2.
- Bus never grants with TIMEOUT=4 -> trap asserted after 4 REQ cycles, cause 4, bus_req drops. Repeat with TIMEOUT=0 -> no trap after 1000 cycles.
- Assert rst during MEM_WAIT, then deliver a late rvalid -> bus_req=0 immediately, response ignored, fetch restarts at RESET_PC.
